// File: rtl/ltc2308_emulator_pkg.sv
// Shared definitions for the LTC2308 device-side emulator.
package ltc2308_emulator_pkg;

  localparam int CFG_BITS  = 6;
  localparam int DATA_BITS = 12;

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, ch0, unipolar
  localparam logic [CFG_BITS-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  // PRBS31, x^31 + x^28 + 1
  localparam logic [30:0] PRBS_SEED   = 31'h34013FF7;
  localparam int          PRBS_TAP_HI = 30;
  localparam int          PRBS_TAP_LO = 27;

  // Advance a Fibonacci PRBS31 register by a constant number of steps.
  function automatic logic [30:0] prbs_advance(input logic [30:0] r,
                                               input int unsigned steps);
    logic [30:0] v;
    v = r;
    for (int unsigned i = 0; i < steps; i++) begin
      v = {v[29:0], v[PRBS_TAP_HI] ^ v[PRBS_TAP_LO]};
    end
    return v;
  endfunction

endpackage

// File: rtl/ltc2308_emulator_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses for an asynchronous pin.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // synchronizer chain plus one history register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ltc2308_emulator.sv
// LTC2308 responder: answers convst/sck/sdi with deterministic channel-tagged frames.
module ltc2308_emulator
  import ltc2308_emulator_pkg::*;
#(
  parameter int CONV_CYCLES = 256,
  parameter int DATA_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  output logic [5:0]  cur_config,
  output logic [15:0] sample_count,
  output logic        protocol_err,
  input  logic        err_clear
);

  localparam logic [15:0] CONV_LOAD = 16'(CONV_CYCLES - 1);
  localparam logic [2:0]  CFG_FULL  = 3'(CFG_BITS);
  localparam logic [3:0]  OUT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  OUT_DONE  = 4'(DATA_BITS);

  logic convst_rise;
  logic sck_rise;
  logic sck_fall;
  logic unused_convst_fall;
  logic sdi_meta;
  logic sdi_sync;

  state_t state;
  state_t state_next;

  logic [15:0]          conv_cnt;
  logic [DATA_BITS-1:0] out_sh;
  logic [3:0]           out_cnt;
  logic [CFG_BITS-1:0]  cfg_sh;
  logic [2:0]           cfg_cnt;
  logic [8:0]           pat_cnt [8];
  logic [30:0]          prbs;

  logic                 load_conv;
  logic                 latch;
  logic                 commit;
  logic                 set_err;
  logic                 shift_out;
  logic                 shift_cfg;
  logic [2:0]           chan;
  logic [DATA_BITS-1:0] sample;

  sync_edge u_sync_convst (
    .clk   (clk),
    .reset (reset),
    .din   (adc_convst),
    .rise  (convst_rise),
    .fall  (unused_convst_fall)
  );

  sync_edge u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (adc_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // sdi only needs its synchronized level, aligned with the sck sync depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= adc_sdi;
      sdi_sync <= sdi_meta;
    end
  end

  // O/S, S1, S0 follow the LTC2308 single-ended mux table, so the channel
  // number is {S1, S0, O/S} (e.g. O/S=1 alone selects ch1).
  assign chan   = {cur_config[3], cur_config[2], cur_config[4]};
  assign sample = (DATA_MODE == 1) ? prbs[30:19] : {chan, pat_cnt[chan]};

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // next-state and per-cycle action strobes; convst always wins over sck
  always_comb begin
    state_next = state;
    load_conv  = 1'b0;
    latch      = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    shift_out  = 1'b0;
    shift_cfg  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (convst_rise) begin
          load_conv  = 1'b1;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (convst_rise) begin
          set_err   = 1'b1;
          load_conv = 1'b1;
        end else begin
          if (sck_rise || sck_fall) set_err = 1'b1;
          if (conv_cnt == '0) begin
            latch      = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (convst_rise) begin
          load_conv  = 1'b1;
          state_next = ST_CONVERT;
          if (cfg_cnt == CFG_FULL) commit  = 1'b1;
          else                     set_err = 1'b1;
        end else begin
          shift_cfg = sck_rise && (cfg_cnt < CFG_FULL);
          shift_out = sck_fall;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // conversion timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        conv_cnt <= '0;
    else if (load_conv)                               conv_cnt <= CONV_LOAD;
    else if (state == ST_CONVERT && conv_cnt != '0)   conv_cnt <= conv_cnt - 16'd1;
  end

  // output shifter; sdo is held low once all data bits have gone out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sh  <= '0;
      out_cnt <= '0;
      adc_sdo <= 1'b0;
    end else if (latch) begin
      out_sh  <= sample;
      out_cnt <= '0;
      adc_sdo <= sample[DATA_BITS-1];
    end else if (load_conv) begin
      adc_sdo <= 1'b0;
    end else if (shift_out) begin
      out_sh  <= {out_sh[DATA_BITS-2:0], 1'b0};
      adc_sdo <= (out_cnt < OUT_LAST) ? out_sh[DATA_BITS-2] : 1'b0;
      if (out_cnt != OUT_DONE) out_cnt <= out_cnt + 4'd1;
    end
  end

  // configuration capture and commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_sh     <= '0;
      cfg_cnt    <= '0;
      cur_config <= CFG_RESET;
    end else begin
      if (commit) cur_config <= cfg_sh;
      if (latch) begin
        cfg_cnt <= '0;
      end else if (shift_cfg) begin
        cfg_sh  <= {cfg_sh[CFG_BITS-2:0], sdi_sync};
        cfg_cnt <= cfg_cnt + 3'd1;
      end
    end
  end

  // data pattern generators advance once per latched sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) pat_cnt[i] <= '0;
      prbs <= PRBS_SEED;
    end else if (latch) begin
      if (DATA_MODE == 1) prbs <= prbs_advance(prbs, DATA_BITS);
      else                pat_cnt[chan] <= pat_cnt[chan] + 9'd1;
    end
  end

  // completed-conversion counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sample_count <= '0;
    else if (latch) sample_count <= sample_count + 16'd1;
  end

  // sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          protocol_err <= 1'b0;
    else if (set_err)   protocol_err <= 1'b1;
    else if (err_clear) protocol_err <= 1'b0;
  end

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed bench for ltc2308_emulator: one counter-mode and one PRBS-mode instance on shared pins.
module tb_ltc2308_emulator;
  import ltc2308_emulator_pkg::*;

  localparam int C = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic adc_convst = 1'b0;
  logic adc_sck = 1'b0;
  logic adc_sdi = 1'b0;
  logic err_clear = 1'b0;

  logic        sdo0, sdo1;
  logic [5:0]  cfg0, cfg1;
  logic [15:0] cnt0, cnt1;
  logic        err0, err1;

  int errors = 0;
  int checks = 0;

  logic [30:0] prbs_ref;
  logic [11:0] d0, d1;

  always #5 clk = ~clk;

  ltc2308_emulator #(.CONV_CYCLES(C), .DATA_MODE(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (sdo0),
    .cur_config   (cfg0),
    .sample_count (cnt0),
    .protocol_err (err0),
    .err_clear    (err_clear)
  );

  ltc2308_emulator #(.CONV_CYCLES(C), .DATA_MODE(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (sdo1),
    .cur_config   (cfg1),
    .sample_count (cnt1),
    .protocol_err (err1),
    .err_clear    (err_clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference PRBS31 (x^31 + x^28 + 1), 12 steps per conversion
  function automatic logic [30:0] ref_adv(input logic [30:0] r);
    logic [30:0] v;
    v = r;
    for (int k = 0; k < 12; k++) v = {v[29:0], v[30] ^ v[27]};
    return v;
  endfunction

  task automatic pulse_convst();
    adc_convst = 1'b1;
    #40;
    adc_convst = 1'b0;
  endtask

  task automatic wait_conv();
    #((C + 5) * 10 - 40);
  endtask

  task automatic shift_frame(input logic [5:0] cfg, input int nsck,
                             output logic [11:0] q0, output logic [11:0] q1);
    q0 = '0;
    q1 = '0;
    q0[11] = sdo0;
    q1[11] = sdo1;
    for (int i = 0; i < nsck; i++) begin
      adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
      #30 adc_sck = 1'b1;
      #30 adc_sck = 1'b0;
      #40;
      if (i < 11) begin
        q0[10-i] = sdo0;
        q1[10-i] = sdo1;
      end
    end
    adc_sdi = 1'b0;
  endtask

  task automatic frame(input logic [5:0] cfg, input int nsck,
                       output logic [11:0] q0, output logic [11:0] q1);
    pulse_convst();
    wait_conv();
    shift_frame(cfg, nsck, q0, q1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    reset = 1'b1;
    #30 reset = 1'b0;
    #20;
    check("rst_sdo", 32'(sdo0), 32'd0);
    check("rst_cfg", 32'(cfg0), 32'h22);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_state", 32'(dut0.state), 32'(ST_IDLE));
    prbs_ref = PRBS_SEED;

    // frame 1: ch0 from reset config, shift in 110010
    frame(6'b110010, 16, d0, d1);
    check("f1_data", 32'(d0), 32'h000);
    check("f1_prbs", 32'(d1), 32'h680);
    prbs_ref = ref_adv(prbs_ref);
    check("f1_tail_sdo", 32'(sdo0), 32'd0);
    check("f1_cfg_hold", 32'(cfg0), 32'h22);

    // frame 2: commit 110010 -> ch1; shift in 101010 (ch4)
    pulse_convst();
    #20;
    check("f2_cfg_commit", 32'(cfg0), 32'h32);
    #((C + 5) * 10 - 60);
    shift_frame(6'b101010, 16, d0, d1);
    check("f2_data", 32'(d0), 32'h200);
    check("f2_prbs", 32'(d1), 32'(prbs_ref[30:19]));
    prbs_ref = ref_adv(prbs_ref);
    check("f2_count", 32'(cnt0), 32'd2);
    check("f2_err", 32'(err0), 32'd0);

    // frame 3: ch4, exact MSB latency, then only 4 config bits
    pulse_convst();
    #(10 * (C + 2) - 40);
    check("f3_pre_msb", 32'(sdo0), 32'd0);
    #10;
    check("f3_msb_time", 32'(sdo0), 32'd1);
    #20;
    shift_frame(6'b100010, 4, d0, d1);
    check("f3_msbs", 32'(d0[11:7]), 32'b10000);
    prbs_ref = ref_adv(prbs_ref);

    // frame 4: short config -> error, old config kept
    pulse_convst();
    #20;
    check("f4_err_short", 32'(err0), 32'd1);
    check("f4_cfg_keep", 32'(cfg0), 32'h2A);
    #((C + 5) * 10 - 60);
    shift_frame(6'b100010, 16, d0, d1);
    check("f4_data", 32'(d0), 32'h801);
    prbs_ref = ref_adv(prbs_ref);
    err_clear = 1'b1;
    #10 err_clear = 1'b0;
    #10;
    check("f4_err_clear", 32'(err0), 32'd0);

    // frame 5: sck toggle during conversion
    pulse_convst();
    #20 adc_sck = 1'b1;
    #30 adc_sck = 1'b0;
    #((C + 5) * 10 - 90);
    check("f5_err_sck", 32'(err0), 32'd1);
    check("f5_cfg", 32'(cfg0), 32'h22);
    shift_frame(6'b100010, 16, d0, d1);
    check("f5_data", 32'(d0), 32'h001);
    prbs_ref = ref_adv(prbs_ref);
    err_clear = 1'b1;
    #10 err_clear = 1'b0;
    #10;

    // frame 6: reset at bit 5
    frame(6'b100010, 5, d0, d1);
    check("f6_count_pre", 32'(cnt0), 32'd6);
    reset = 1'b1;
    #1;
    check("f6_rst_sdo", 32'(sdo0), 32'd0);
    check("f6_rst_state", 32'(dut0.state), 32'(ST_IDLE));
    check("f6_rst_count", 32'(cnt0), 32'd0);
    check("f6_rst_cfg", 32'(cfg0), 32'h22);
    #29 reset = 1'b0;
    #20;
    prbs_ref = PRBS_SEED;

    // three back-to-back ch0 frames after reset
    frame(6'b100010, 16, d0, d1);
    check("p1_data", 32'(d0), 32'h000);
    check("p1_prbs", 32'(d1), 32'h680);
    prbs_ref = ref_adv(prbs_ref);
    frame(6'b100010, 16, d0, d1);
    check("p2_data", 32'(d0), 32'h001);
    check("p2_prbs", 32'(d1), 32'(prbs_ref[30:19]));
    prbs_ref = ref_adv(prbs_ref);
    frame(6'b100010, 16, d0, d1);
    check("p3_data", 32'(d0), 32'h002);
    check("p3_prbs", 32'(d1), 32'(prbs_ref[30:19]));
    check("p3_count", 32'(cnt0), 32'd3);
    check("p3_err", 32'(err0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
